// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between instruction fetch and data access, data first
module mem_port_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_re,
  output logic        ram_we,
  input  logic [31:0] ram_rdata,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        stall
);
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;
  state_t state;
  logic [3:0] cnt;
  logic grant_d, grant_i, last;
  // a port being acknowledged in DONE still shows its request; it must not win again
  always_comb begin
    grant_d = (mem_rd | mem_wr) && state != DONE_D;
    grant_i = !grant_d && if_req && state != DONE_I;
    last = cnt == 4'(LATENCY - 1);
    stall = (if_req & ~if_ready) | ((mem_rd | mem_wr) & ~mem_ready);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      ram_re <= 1'b0;
      ram_we <= 1'b0;
      if_ready <= 1'b0;
      mem_ready <= 1'b0;
      ram_addr <= 32'd0;
      ram_wdata <= 32'd0;
      if_rdata <= 32'd0;
      mem_rdata <= 32'd0;
    end else begin
      if_ready <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        BUSY_I, BUSY_D: begin
          cnt <= last ? 4'd0 : cnt + 4'd1;
          if (last) begin
            ram_re <= 1'b0;
            ram_we <= 1'b0;
            if (state == BUSY_I) begin
              state <= DONE_I;
              if_ready <= 1'b1;
              if_rdata <= ram_rdata;
            end else begin
              state <= DONE_D;
              mem_ready <= 1'b1;
              if (ram_re) mem_rdata <= ram_rdata;
            end
          end
        end
        default: begin
          state <= grant_d ? BUSY_D : grant_i ? BUSY_I : IDLE;
          if (grant_d) begin
            ram_addr <= mem_addr;
            ram_wdata <= mem_wdata;
            ram_we <= mem_wr;
            ram_re <= ~mem_wr;
          end else if (grant_i) begin
            ram_addr <= if_addr;
            ram_re <= 1'b1;
            ram_we <= 1'b0;
          end
        end
      endcase
    end
endmodule
